// File: rtl/inst_fetch_ctrl_if.sv
// Fetch-port and byte-RAM signal bundle for inst_fetch_ctrl.
// slave = the controller, master = core plus program memory.
interface inst_fetch_ctrl_if #(
    parameter int ADDR_W = 17
);
    logic              rom_ce_i;
    logic [31:0]       rom_addr_i;
    logic [31:0]       rom_data_o;
    logic              rom_ready_o;
    logic              stall_req_o;
    logic [ADDR_W-1:0] mem_a_o;
    logic              mem_rd_o;
    logic [7:0]        mem_din_i;

    modport slave (
        input  rom_ce_i, rom_addr_i, mem_din_i,
        output rom_data_o, rom_ready_o, stall_req_o,
        output mem_a_o, mem_rd_o
    );

    modport master (
        output rom_ce_i, rom_addr_i, mem_din_i,
        input  rom_data_o, rom_ready_o, stall_req_o,
        input  mem_a_o, mem_rd_o
    );
endinterface

// File: rtl/inst_fetch_ctrl.sv
// Instruction-fetch responder: builds 32-bit words from four byte-RAM reads.
// INST_LAST_HIT_EN adds a one-entry last-word hit buffer.
module inst_fetch_ctrl #(
    parameter int ADDR_W = 17
) (
    input  logic                clk,
    input  logic                rst,
    inst_fetch_ctrl_if.slave    bus
);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] RD0  = 3'd1;
    localparam logic [2:0] RD1  = 3'd2;
    localparam logic [2:0] RD2  = 3'd3;
    localparam logic [2:0] RD3  = 3'd4;
    localparam logic [2:0] LAST = 3'd5;

    logic [2:0]        state;
    logic [ADDR_W-1:0] a;
    logic [ADDR_W-1:0] req_a;
    logic [23:0]       bytes_q;
    logic [31:0]       rom_data;
    logic              rom_ready;
    logic              keep;
    logic              accept;
    logic              in_rd;
    logic [1:0]        off;
    logic              hit;
    logic [31:0]       hit_word;
    logic              unused_hi;

    assign req_a     = bus.rom_addr_i[ADDR_W-1:0];
    assign unused_hi = ^bus.rom_addr_i[31:ADDR_W];
    assign keep      = bus.rom_ce_i && (req_a == a);
    assign accept    = bus.rom_ce_i && !rom_ready;
    assign in_rd     = (state >= RD0) && (state <= RD3);
    assign off       = 2'(state - RD0);

    assign bus.mem_rd_o    = in_rd;
    assign bus.mem_a_o     = in_rd ? a + ADDR_W'(off) : '0;
    assign bus.rom_data_o  = rom_data;
    assign bus.rom_ready_o = rom_ready;
    assign bus.stall_req_o = rst & bus.rom_ce_i & ~rom_ready;

`ifdef INST_LAST_HIT_EN
    logic [ADDR_W-1:0] hit_tag;
    logic              hit_vld;

    assign hit = hit_vld && (req_a == hit_tag);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_vld  <= 1'b0;
            hit_tag  <= '0;
            hit_word <= '0;
        end else if (state == LAST && keep) begin
            hit_vld  <= 1'b1;
            hit_tag  <= a;
            hit_word <= {bus.mem_din_i, bytes_q};
        end
    end
`else
    assign hit      = 1'b0;
    assign hit_word = '0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            a         <= '0;
            bytes_q   <= '0;
            rom_data  <= '0;
            rom_ready <= 1'b0;
        end else begin
            rom_ready <= 1'b0;
            if (state == IDLE) begin
                if (accept && hit) begin
                    rom_data  <= hit_word;
                    rom_ready <= 1'b1;
                end else if (accept) begin
                    a     <= req_a;
                    state <= RD0;
                end
            end else if (!keep) begin
                // redirect or dropped request: discard the partial word
                state <= IDLE;
            end else begin
                unique case (state)
                    RD0: state <= RD1;
                    RD1: begin
                        bytes_q[7:0] <= bus.mem_din_i;
                        state        <= RD2;
                    end
                    RD2: begin
                        bytes_q[15:8] <= bus.mem_din_i;
                        state         <= RD3;
                    end
                    RD3: begin
                        bytes_q[23:16] <= bus.mem_din_i;
                        state          <= LAST;
                    end
                    LAST: begin
                        rom_data  <= {bus.mem_din_i, bytes_q};
                        rom_ready <= 1'b1;
                        state     <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Scoreboard bench for inst_fetch_ctrl against a 1-cycle byte RAM
// holding mem[i] = i[7:0].
module tb_inst_fetch_ctrl;
    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_cmp;
    int   n_bad;
    exp_t        exp_q[$];
    logic [16:0] mem_q[$];

    inst_fetch_ctrl_if #(.ADDR_W(17)) bus ();

    inst_fetch_ctrl #(.ADDR_W(17)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk)
        if (bus.mem_rd_o) bus.mem_din_i <= bus.mem_a_o[7:0];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_mem(input logic [16:0] base, input int n);
        for (int i = 0; i < n; i++) mem_q.push_back(base + 17'(i));
    endtask

    task automatic req(input logic [31:0] addr, input logic [31:0] data,
                       input int lat, input bit mem);
        exp_t e;
        bus.rom_ce_i   = 1'b1;
        bus.rom_addr_i = addr;
        e.data = data;
        e.cyc  = cyc + lat;
        exp_q.push_back(e);
        if (mem) push_mem(addr[16:0], 4);
    endtask

    // monitor: pops expectations whenever the DUT presents a read or a ready
    always @(negedge clk) begin
        if (rst) begin
            if (bus.mem_rd_o) begin
                if (mem_q.size() == 0)
                    chk("unexpected_mem_rd", 32'(bus.mem_a_o), 32'hffff_ffff);
                else
                    chk("mem_a", 32'(bus.mem_a_o), 32'(mem_q.pop_front()));
            end else begin
                chk("mem_a_idle", 32'(bus.mem_a_o), 32'h0);
            end
            if (bus.rom_ready_o) begin
                chk("stall_in_ready", 32'(bus.stall_req_o), 32'h0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_ready", bus.rom_data_o, 32'hffff_ffff);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("rom_data", bus.rom_data_o, e.data);
                    chk("ready_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        bit hit_build;
        n_cmp = 0;
        n_bad = 0;
        rst            = 1'b0;
        bus.rom_ce_i   = 1'b1;
        bus.rom_addr_i = 32'h0000_0010;
        bus.mem_din_i  = 8'h00;
`ifdef INST_LAST_HIT_EN
        hit_build = 1'b1;
`else
        hit_build = 1'b0;
`endif
        tick(2);
        chk("rst_data",  bus.rom_data_o, 32'h0);
        chk("rst_ready", 32'(bus.rom_ready_o), 32'h0);
        chk("rst_stall", 32'(bus.stall_req_o), 32'h0);
        chk("rst_mem_rd", 32'(bus.mem_rd_o), 32'h0);
        chk("rst_mem_a", 32'(bus.mem_a_o), 32'h0);

        // 1: first fetch after reset
        rst = 1'b1;
        req(32'h0000_0010, 32'h1312_1110, 6, 1'b1);
        #1;
        chk("stall_pending", 32'(bus.stall_req_o), 32'h1);
        tick(6);

        // 2: core advances pc in the ready cycle
        req(32'h0000_0014, 32'h1716_1514, 7, 1'b1);
        tick(7);
        bus.rom_ce_i = 1'b0;
        tick(2);

        // 3: redirect during RD2
        bus.rom_ce_i   = 1'b1;
        bus.rom_addr_i = 32'h0000_0020;
        push_mem(17'h20, 3);
        tick(3);
        req(32'h0000_0040, 32'h4342_4140, 7, 1'b1);
        tick(7);
        bus.rom_ce_i = 1'b0;
        tick(2);

        // 4: reset during RD2
        bus.rom_ce_i   = 1'b1;
        bus.rom_addr_i = 32'h0000_0030;
        push_mem(17'h30, 2);
        tick(3);
        rst = 1'b0;
        #1;
        chk("arst_data",  bus.rom_data_o, 32'h0);
        chk("arst_ready", 32'(bus.rom_ready_o), 32'h0);
        chk("arst_stall", 32'(bus.stall_req_o), 32'h0);
        chk("arst_mem_rd", 32'(bus.mem_rd_o), 32'h0);
        chk("arst_mem_a", 32'(bus.mem_a_o), 32'h0);
        tick(1);
        rst = 1'b1;
        req(32'h0000_0030, 32'h3332_3130, 6, 1'b1);
        tick(6);
        bus.rom_ce_i = 1'b0;
        tick(2);

        // 5: address wrap at 2^17
        req(32'h0001_fffe, 32'h0100_fffe, 6, 1'b1);
        tick(6);
        bus.rom_ce_i = 1'b0;
        tick(2);

        // unaligned fetch
        req(32'h0000_1005, 32'h0807_0605, 6, 1'b1);
        tick(6);
        bus.rom_ce_i = 1'b0;
        tick(2);

        // upper address bits are ignored
        req(32'habcc_0024, 32'h2726_2524, 6, 1'b1);
        tick(6);
        bus.rom_ce_i = 1'b0;
        tick(2);

        // 6: re-request of the last fetched word
        req(32'h0000_0010, 32'h1312_1110, 6, 1'b1);
        tick(6);
        bus.rom_ce_i = 1'b0;
        tick(1);
        lat = hit_build ? 1 : 6;
        req(32'h0000_0010, 32'h1312_1110, lat, !hit_build);
        tick(lat);
        bus.rom_ce_i = 1'b0;
        tick(2);

        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0 && mem_q.size() == 0) break;
            tick(1);
        end
        chk("pending_ready", 32'(exp_q.size()), 32'h0);
        chk("pending_mem", 32'(mem_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
